// File: rtl/rv32i_mem_responder.sv
// Memory-bus responder for the rv32i core: word RAM plus a small MMIO block
// (console TX FIFO, status, free-running cycle counter, halt/exit register).
module rv32i_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    output logic [31:0] mem_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        halt,
    output logic [31:0] halt_code,
    output logic        bus_err
);

    localparam int unsigned RAM_WORDS = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);

    localparam logic [5:0] OFF_CON_TX = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h01;
    localparam logic [5:0] OFF_CYCLE  = 6'h02;
    localparam logic [5:0] OFF_HALT   = 6'h03;

    localparam logic [PTR_W:0] PTR_ONE = PTR_W'(1) | {(PTR_W+1){1'b0}};

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    // Address decode
    logic                  sel_ram;
    logic                  sel_mmio;
    logic                  sel_unmapped;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [5:0]            mmio_off;
    logic                  wr_en;
    logic                  unused_addr_bits;

    assign sel_ram          = (mem_addr[31:ADDR_WIDTH+2] == '0);
    assign sel_mmio         = !sel_ram && (mem_addr[31:8] == MMIO_BASE[31:8]);
    assign sel_unmapped     = !sel_ram && !sel_mmio;
    assign ram_idx          = mem_addr[ADDR_WIDTH+1:2];
    assign mmio_off         = mem_addr[7:2];
    assign unused_addr_bits = ^mem_addr[1:0];

    // Writes presented while reset is held must not touch the (unreset) RAM either.
    assign wr_en = mem_we && !rst;

    // Word RAM, deliberately not reset so the bench can preload it
    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en && sel_ram) begin
            ram[ram_idx] <= mem_wdata;
        end
    end

    // Console FIFO: extra pointer bit distinguishes full from empty
    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push_req;
    logic           push;
    logic           pop;
    logic           drop;
    logic           overflow;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = !fifo_empty && con_ready;
    assign push_req   = wr_en && sel_mmio && (mmio_off == OFF_CON_TX);
    // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;

    assign con_valid  = !fifo_empty;
    assign con_data   = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= mem_wdata[7:0];
        end
    end

    // Control state: FIFO pointers, sticky flags, counter, halt register
    logic [31:0] cycle_cnt;
    logic        cycle_wr;
    logic        halt_wr;

    assign cycle_wr = wr_en && sel_mmio && (mmio_off == OFF_CYCLE);
    assign halt_wr  = wr_en && sel_mmio && (mmio_off == OFF_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            cycle_cnt <= 32'h0;
            halt      <= 1'b0;
            halt_code <= 32'h0;
            bus_err   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (cycle_wr) begin
                cycle_cnt <= mem_wdata;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (halt_wr) begin
                halt      <= 1'b1;
                halt_code <= mem_wdata;
            end
            if (wr_en && sel_unmapped) begin
                bus_err <= 1'b1;
            end
        end
    end

    // Combinational read path; MMIO reads show state from before the current edge
    always_comb begin
        mem_rdata = 32'h0;
        if (sel_ram) begin
            mem_rdata = ram[ram_idx];
        end else if (sel_mmio) begin
            case (mmio_off)
                OFF_STATUS: mem_rdata = {29'h0, overflow, fifo_full, fifo_empty};
                OFF_CYCLE:  mem_rdata = cycle_cnt;
                OFF_HALT:   mem_rdata = halt_code;
                default:    mem_rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_mem_responder.sv
// Bench for rv32i_mem_responder: directed scenarios plus randomized traffic
// checked against a queue/array model of the responder's bus-visible behaviour.
module tb_rv32i_mem_responder;

    localparam int AW    = 10;
    localparam int DEPTH = 8;
    localparam logic [31:0] A_CON  = 32'h0001_0000;
    localparam logic [31:0] A_STAT = 32'h0001_0004;
    localparam logic [31:0] A_CYC  = 32'h0001_0008;
    localparam logic [31:0] A_HLT  = 32'h0001_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_rdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready = 1'b0;
    logic        halt;
    logic [31:0] halt_code;
    logic        bus_err;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    rv32i_mem_responder #(
        .ADDR_WIDTH(AW),
        .FIFO_DEPTH(DEPTH),
        .MMIO_BASE (32'h0001_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .con_valid(con_valid),
        .con_data (con_data),
        .con_ready(con_ready),
        .halt     (halt),
        .halt_code(halt_code),
        .bus_err  (bus_err)
    );

    // Reference model
    logic [31:0] m_ram [1 << AW];
    logic [7:0]  m_q[$];
    bit          m_ovf;
    bit          m_halt;
    bit          m_err;
    logic [31:0] m_cycle;
    logic [31:0] m_code;

    function automatic void model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_halt  = 1'b0;
        m_err   = 1'b0;
        m_cycle = 32'h0;
        m_code  = 32'h0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (a < 32'h0000_1000) return m_ram[a[11:2]];
        if (a[31:8] == 24'h00_0100) begin
            case (a[7:2])
                6'd1:    return {29'h0, m_ovf, (m_q.size() == DEPTH), (m_q.size() == 0)};
                6'd2:    return m_cycle;
                6'd3:    return m_code;
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    function automatic logic [7:0] exp_con();
        return (m_q.size() != 0) ? m_q[0] : 8'h00;
    endfunction

    // Apply one rising edge to the model using the inputs currently driven, then advance the DUT.
    task automatic step();
        bit pop;
        bit full;
        bit cyc_loaded;
        if (!rst) begin
            pop        = (m_q.size() != 0) && con_ready;
            full       = (m_q.size() == DEPTH);
            cyc_loaded = 1'b0;
            if (pop) void'(m_q.pop_front());
            if (mem_we) begin
                if (mem_addr < 32'h0000_1000) begin
                    m_ram[mem_addr[11:2]] = mem_wdata;
                end else if (mem_addr[31:8] == 24'h00_0100) begin
                    case (mem_addr[7:2])
                        6'd0: if (full && !pop) m_ovf = 1'b1; else m_q.push_back(mem_wdata[7:0]);
                        6'd2: begin m_cycle = mem_wdata; cyc_loaded = 1'b1; end
                        6'd3: begin m_halt = 1'b1; m_code = mem_wdata; end
                        default: ;
                    endcase
                end else begin
                    m_err = 1'b1;
                end
            end
            if (!cyc_loaded) m_cycle = m_cycle + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        step();
        mem_we    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        model_reset();
        #2;
        checks++; if (con_valid !== 1'b0) begin fails++; $display("FAIL rst_con_valid got=%b exp=0", con_valid); end
        checks++; if (con_data !== 8'h00) begin fails++; $display("FAIL rst_con_data got=%h exp=00", con_data); end
        checks++; if (halt !== 1'b0) begin fails++; $display("FAIL rst_halt got=%b exp=0", halt); end
        checks++; if (halt_code !== 32'h0) begin fails++; $display("FAIL rst_halt_code got=%h exp=0", halt_code); end
        checks++; if (bus_err !== 1'b0) begin fails++; $display("FAIL rst_bus_err got=%b exp=0", bus_err); end
        mem_addr = A_STAT; #1;
        checks++; if (mem_rdata !== 32'h1) begin fails++; $display("FAIL rst_status got=%h exp=1", mem_rdata); end
        // A write while reset is held is ignored.
        wr(A_HLT, 32'h5);
        checks++; if (halt !== 1'b0) begin fails++; $display("FAIL rst_write_ignored got=%b exp=0", halt); end
        rst = 1'b0;
    endtask

    task automatic test_cycle();
        for (int i = 0; i < 10; i++) step();
        mem_addr = A_CYC; #1;
        checks++; if (mem_rdata !== 32'd10) begin fails++; $display("FAIL cycle_after10 got=%0d exp=10", mem_rdata); end
        wr(A_CYC, 32'hFFFF_FFFF);
        mem_addr = A_CYC; #1;
        checks++; if (mem_rdata !== 32'hFFFF_FFFF) begin fails++; $display("FAIL cycle_load got=%h exp=ffffffff", mem_rdata); end
        step();
        checks++; if (mem_rdata !== 32'h0) begin fails++; $display("FAIL cycle_wrap got=%h exp=0", mem_rdata); end
    endtask

    task automatic test_ram();
        wr(32'h40, 32'h1234_5678);
        mem_addr = 32'h40; #1;
        checks++; if (mem_rdata !== 32'h1234_5678) begin fails++; $display("FAIL ram_rd40 got=%h exp=12345678", mem_rdata); end
        mem_addr = 32'h42; #1;
        checks++; if (mem_rdata !== 32'h1234_5678) begin fails++; $display("FAIL ram_rd42 got=%h exp=12345678", mem_rdata); end
        mem_addr = 32'h44; #1;
        checks++; if (mem_rdata !== m_ram[17]) begin fails++; $display("FAIL ram_rd44 got=%h exp=%h", mem_rdata, m_ram[17]); end
    endtask

    task automatic test_console();
        con_ready = 1'b0;
        wr(A_CON, 32'h48);
        wr(A_CON, 32'h69);
        mem_addr = A_STAT; #1;
        checks++; if (mem_rdata !== 32'h0) begin fails++; $display("FAIL con_status_busy got=%h exp=0", mem_rdata); end
        checks++; if (con_valid !== 1'b1) begin fails++; $display("FAIL con_valid_q got=%b exp=1", con_valid); end
        checks++; if (con_data !== 8'h48) begin fails++; $display("FAIL con_head got=%h exp=48", con_data); end
        con_ready = 1'b1;
        step();
        checks++; if (con_valid !== 1'b1 || con_data !== 8'h69) begin fails++; $display("FAIL con_second got=%b/%h exp=1/69", con_valid, con_data); end
        step();
        checks++; if (con_valid !== 1'b0) begin fails++; $display("FAIL con_drained got=%b exp=0", con_valid); end
        checks++; if (mem_rdata !== 32'h1) begin fails++; $display("FAIL con_status_empty got=%h exp=1", mem_rdata); end
        con_ready = 1'b0;
    endtask

    task automatic test_overflow();
        con_ready = 1'b0;
        for (int b = 1; b <= 9; b++) wr(A_CON, 32'(b));
        mem_addr = A_STAT; #1;
        checks++; if (mem_rdata !== 32'h6) begin fails++; $display("FAIL ovf_status got=%h exp=6", mem_rdata); end
        con_ready = 1'b1;
        for (int b = 1; b <= 8; b++) begin
            checks++; if (con_valid !== 1'b1 || con_data !== 8'(b)) begin fails++; $display("FAIL ovf_drain got=%b/%h exp=1/%h", con_valid, con_data, 8'(b)); end
            step();
        end
        checks++; if (mem_rdata !== 32'h5) begin fails++; $display("FAIL ovf_sticky got=%h exp=5", mem_rdata); end
        con_ready = 1'b0;
        do_reset();
        for (int b = 8'h11; b <= 8'h18; b++) wr(A_CON, 32'(b));
        mem_addr = A_STAT; #1;
        checks++; if (mem_rdata !== 32'h2) begin fails++; $display("FAIL full_status got=%h exp=2", mem_rdata); end
        con_ready = 1'b1;
        wr(A_CON, 32'h19);
        mem_addr = A_STAT; #1;
        checks++; if (mem_rdata !== 32'h2) begin fails++; $display("FAIL push_pop_full got=%h exp=2", mem_rdata); end
        for (int b = 8'h12; b <= 8'h19; b++) begin
            checks++; if (con_valid !== 1'b1 || con_data !== 8'(b)) begin fails++; $display("FAIL pp_drain got=%b/%h exp=1/%h", con_valid, con_data, 8'(b)); end
            step();
        end
        checks++; if (mem_rdata !== 32'h1) begin fails++; $display("FAIL pp_final got=%h exp=1", mem_rdata); end
        con_ready = 1'b0;
    endtask

    task automatic test_halt_reset();
        wr(A_HLT, 32'h1);
        checks++; if (halt !== 1'b1 || halt_code !== 32'h1) begin fails++; $display("FAIL halt_first got=%b/%h exp=1/1", halt, halt_code); end
        wr(A_HLT, 32'h2);
        checks++; if (halt !== 1'b1 || halt_code !== 32'h2) begin fails++; $display("FAIL halt_second got=%b/%h exp=1/2", halt, halt_code); end
        mem_addr = A_HLT; #1;
        checks++; if (mem_rdata !== 32'h2) begin fails++; $display("FAIL halt_read got=%h exp=2", mem_rdata); end
        for (int b = 0; b < 3; b++) wr(A_CON, 32'hA0 + 32'(b));
        checks++; if (con_valid !== 1'b1) begin fails++; $display("FAIL queued3 got=%b exp=1", con_valid); end
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++; if (halt !== 1'b0 || halt_code !== 32'h0) begin fails++; $display("FAIL async_halt got=%b/%h exp=0/0", halt, halt_code); end
        checks++; if (con_valid !== 1'b0 || con_data !== 8'h00) begin fails++; $display("FAIL async_fifo got=%b/%h exp=0/00", con_valid, con_data); end
        mem_addr = A_CYC; #1;
        checks++; if (mem_rdata !== 32'h0) begin fails++; $display("FAIL async_cycle got=%h exp=0", mem_rdata); end
        mem_addr = 32'h40; #1;
        checks++; if (mem_rdata !== 32'h1234_5678) begin fails++; $display("FAIL ram_kept got=%h exp=12345678", mem_rdata); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_unmapped();
        mem_addr = 32'h0000_2000; #1;
        checks++; if (mem_rdata !== 32'h0) begin fails++; $display("FAIL unm_read got=%h exp=0", mem_rdata); end
        step();
        checks++; if (bus_err !== 1'b0) begin fails++; $display("FAIL unm_read_err got=%b exp=0", bus_err); end
        wr(32'h0000_2000, 32'hAAAA_AAAA);
        checks++; if (bus_err !== 1'b1) begin fails++; $display("FAIL unm_write_err got=%b exp=1", bus_err); end
        mem_addr = 32'h0; #1;
        checks++; if (mem_rdata !== m_ram[0]) begin fails++; $display("FAIL alias_word0 got=%h exp=%h", mem_rdata, m_ram[0]); end
        mem_addr = 32'h0000_1000; #1;
        checks++; if (mem_rdata !== 32'h0) begin fails++; $display("FAIL alias_1000 got=%h exp=0", mem_rdata); end
    endtask

    task automatic test_random();
        int op;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            op        = $urandom_range(0, 7);
            con_ready = 1'($urandom_range(0, 1));
            mem_we    = 1'b0;
            mem_wdata = $urandom;
            case (op)
                0:       begin mem_addr = $urandom & 32'h0000_0FFF; mem_we = 1'b1; end
                1:       mem_addr = $urandom & 32'h0000_0FFF;
                2, 3:    begin mem_addr = A_CON; mem_we = 1'b1; end
                4:       begin mem_addr = A_STAT | 32'($urandom_range(0, 3)); mem_we = 1'($urandom_range(0, 1)); end
                5:       begin mem_addr = A_CYC; mem_we = ($urandom_range(0, 9) == 0); end
                6:       begin mem_addr = A_HLT; mem_we = 1'($urandom_range(0, 1)); end
                default: begin mem_addr = 32'h0002_0000 | ($urandom & 32'hFFFC); mem_we = ($urandom_range(0, 7) == 0); end
            endcase
            #1;
            checks++; if (mem_rdata !== exp_rd(mem_addr)) begin fails++; $display("FAIL rnd_rdata n=%0d addr=%h got=%h exp=%h", n, mem_addr, mem_rdata, exp_rd(mem_addr)); end
            checks++; if (con_valid !== (m_q.size() != 0) || con_data !== exp_con()) begin fails++; $display("FAIL rnd_con n=%0d got=%b/%h exp=%b/%h", n, con_valid, con_data, (m_q.size() != 0), exp_con()); end
            checks++; if (halt !== m_halt || halt_code !== m_code) begin fails++; $display("FAIL rnd_halt n=%0d got=%b/%h exp=%b/%h", n, halt, halt_code, m_halt, m_code); end
            checks++; if (bus_err !== m_err) begin fails++; $display("FAIL rnd_bus_err n=%0d got=%b exp=%b", n, bus_err, m_err); end
            step();
        end
        mem_we    = 1'b0;
        con_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        for (int i = 0; i < (1 << AW); i++) begin
            v           = $urandom;
            m_ram[i]    = v;
            dut.ram[i]  = v;
        end
        model_reset();
        test_reset();
        test_cycle();
        test_ram();
        test_console();
        test_overflow();
        test_halt_reset();
        test_unmapped();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
